// File: rtl/ahb_slave_responder_pkg.sv
// AHB encodings shared by the responder slice, plus the lane-mask helper.
// No ports: imported by ahb_slave_responder and its byte memory.
package ahb_slave_responder_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } ahbTransferEnum;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } ahbHsizeEnum;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } ahbRespEnum;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } ahbBurstEnum;

    // Byte lanes touched by a transfer of the given size at addr[1:0].
    function automatic logic [3:0] lane_mask(
        input logic [2:0] size,
        input logic [1:0] lo
    );
        logic [3:0] m;
        m = 4'b1111;
        unique case (1'b1)
            (size == HSIZE_BYTE): m = 4'b0001 << lo;
            (size == HSIZE_HALF): m = 4'b0011 << {lo[1], 1'b0};
            default:              m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_slave_byte_memory.sv
// Four-lane byte RAM, per-lane write enable, combinational read, no reset.
// Ports: clk, we[3:0] lane enables, addr word index, wdata, rdata.
module ahb_slave_byte_memory
    import ahb_slave_responder_pkg::*;
#(
    parameter int WORD_BITS = 10
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic [WORD_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [3:0][7:0] mem_q [2**WORD_BITS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_slave_responder.sv
// AHB-Lite subordinate: byte memory, programmable waits, two-cycle ERROR.
// Ports: AHB slave signals (hclk/hreset/hsel..hready in, hreadyout/hresp/
// hrdata/hexokay out) plus wait_states for the next accepted transfer.
module ahb_slave_responder
    import ahb_slave_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    MEM_ADDR_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] MIN_ADDR      = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] MAX_ADDR      = 32'h0000_0FFF
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hselx,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [3:0]              hprot,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic                    hready,
    input  logic [3:0]              wait_states,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hexokay
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     write_q, write_d;
    logic [2:0]               size_q, size_d;

    logic                     active;
    logic                     accept;
    logic [ADDR_WIDTH:0]      lo_diff;
    logic [ADDR_WIDTH:0]      hi_diff;
    logic                     out_of_range;
    logic                     bad_size;
    logic                     misaligned;
    logic                     xfer_err;
    logic                     rd_en;
    logic [3:0]               mem_we;
    logic [31:0]              mem_rdata;
    logic                     unused_bits;

    assign active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

    // hreadyout is high exactly in the states that may take a new
    // address phase (IDLE, final DATA cycle, second ERROR cycle).
    assign accept = hselx & hready & active & hreadyout;

    // Range test via borrow bits: a zero MIN_ADDR then folds cleanly
    // instead of becoming a constant comparison.
    assign lo_diff = {1'b0, haddr} - {1'b0, MIN_ADDR};
    assign hi_diff = {1'b0, MAX_ADDR} - {1'b0, haddr};

    assign out_of_range = lo_diff[ADDR_WIDTH] | hi_diff[ADDR_WIDTH];
    assign bad_size     = hsize > HSIZE_WORD;
    assign misaligned   = ((hsize == HSIZE_HALF) && haddr[0])
                        || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    assign xfer_err     = out_of_range | bad_size | misaligned;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        unique case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DATA;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    addr_d  = haddr[MEM_ADDR_BITS-1:0];
                    write_d = hwrite;
                    size_d  = hsize;
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else if (wait_states != 4'd0) begin
                        state_d = ST_WAIT;
                        cnt_d   = wait_states;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        rd_en     = 1'b0;
        unique case (state_q)
            ST_WAIT: hreadyout = 1'b0;
            ST_DATA: rd_en = ~write_q;
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Writes commit on the edge that ends the final data cycle.
    assign mem_we = (state_q == ST_DATA && write_q)
                  ? (lane_mask(size_q, addr_q[1:0]) & hwstrb)
                  : 4'b0000;

    ahb_slave_byte_memory #(
        .WORD_BITS (MEM_ADDR_BITS - 2)
    ) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .addr  (addr_q[MEM_ADDR_BITS-1:2]),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    assign hrdata  = rd_en ? mem_rdata : '0;
    assign hexokay = 1'b0;

    assign unused_bits = ^{hburst, hprot,
                           lo_diff[ADDR_WIDTH-1:0],
                           hi_diff[ADDR_WIDTH-1:0]};

endmodule

// File: doc/ahb_slave_responder.md
Name: ahb_slave_responder

Overview:
- Synthesizable AHB-Lite subordinate with a byte-addressed memory and programmable wait states.
- Acts as the responder for the master driver and bench slave-select path; one instance per hselx bit.
- It accepts address phases, inserts wait states, performs reads and writes, and returns OKAY or a two-cycle ERROR.
- It is the reference DUT-side subordinate for master-agent testing.

Parameters:
- ADDR_WIDTH, 32, haddr width.
- DATA_WIDTH, 32, hwdata/hrdata width; only 32 is supported.
- MEM_ADDR_BITS, 12, memory holds 2**MEM_ADDR_BITS bytes, indexed by haddr[MEM_ADDR_BITS-1:0].
- MIN_ADDR, 32'h0000_0000, lowest legal address (inclusive).
- MAX_ADDR, 32'h0000_0FFF, highest legal address (inclusive).

Ports:
- hclk, input, 1, clock.
- hreset, input, 1, asynchronous active-high reset.
- hselx, input, 1, slave select.
- haddr, input, ADDR_WIDTH, address.
- htrans, input, 2, transfer type: IDLE/BUSY/NONSEQ/SEQ.
- hwrite, input, 1, 1 = write.
- hsize, input, 3, transfer size.
- hburst, input, 3, burst type; ignored except for coverage.
- hprot, input, 4, protection; ignored.
- hwdata, input, DATA_WIDTH, write data.
- hwstrb, input, DATA_WIDTH/8, write byte strobes.
- hready, input, 1, combined bus ready.
- wait_states, input, 4, wait cycles for the next accepted transfer.
- hreadyout, output, 1, transfer done.
- hresp, output, 1, 0 = OKAY, 1 = ERROR.
- hrdata, output, DATA_WIDTH, read data.
- hexokay, output, 1, exclusive okay; tied 0.

Behaviour:
- Reset (asynchronous, any cycle, including mid-transfer):
  - FSM goes to ST_IDLE; hreadyout=1, hresp=0, hrdata=0, hexokay=0, wait counter=0.
  - Memory contents are NOT reset.
- Accept condition (sampled on the rising edge):
  - Accept when hselx & hready & htrans[1].
  - On accept, register addr, hwrite, hsize and wait_states; then classify.
- ERROR classification at accept:
  - addr < MIN_ADDR or addr > MAX_ADDR;
  - hsize > WORD;
  - misaligned: HALFWORD with addr[0]!=0, or WORD with addr[1:0]!=0.
- IDLE or BUSY with hselx & hready: zero-wait OKAY; no state change beyond ST_IDLE.
- FSM states and transitions:
  - ST_IDLE (hreadyout=1, hresp=0): go to ST_ERR1 if the accepted transfer is an error. Otherwise go to ST_WAIT if wait_states>0, else ST_DATA.
  - ST_WAIT (hreadyout=0, hresp=0): decrement the counter each cycle; go to ST_DATA when the counter reaches 1.
  - ST_DATA (hreadyout=1, hresp=0): final data cycle. A new accept in this cycle is evaluated exactly as from ST_IDLE, giving back-to-back pipelining; otherwise return to ST_IDLE.
  - ST_ERR1 (hreadyout=0, hresp=1) always goes to ST_ERR2.
  - ST_ERR2 (hreadyout=1, hresp=1) evaluates a new accept like ST_DATA; otherwise goes to ST_IDLE.
- Latency: the data phase is wait_states+1 cycles for OKAY and exactly 2 cycles for ERROR.
- Write commit:
  - Commits at the rising edge ending ST_DATA.
  - Byte lane i is written when lane_mask[i] & hwstrb[i].
  - lane_mask is derived from the registered hsize and addr[1:0]: BYTE gives one lane, HALFWORD two lanes, WORD all four.
  - Erroring writes never modify memory.
- Read data:
  - In ST_DATA of a read, hrdata is driven combinationally from the memory word at {addr[MEM_ADDR_BITS-1:2],2'b00}; all lanes are driven.
  - hrdata is 0 in every other state.
  - A read immediately following a write to the same word returns the new data, because the write commits before the read's data phase.
- hreadyout must be high in every cycle where the slave is not in a data phase.
- Write at addr beyond 2**MEM_ADDR_BITS but within [MIN,MAX]: the index wraps modulo the memory size.

Decomposition:
- Shared AHB global package holds ahbTransferEnum, ahbHsizeEnum, ahbRespEnum and ahbBurstEnum.
- The FSM state enum (ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2) is local.
- One sub-module, ahb_slave_byte_memory, provides:
  - a 4-lane byte RAM with per-lane write enable;
  - a combinational read port;
  - no reset.

Test Plan:
- Reset check: hreset pulsed mid-ST_WAIT -> next cycle hreadyout=1, hresp=0, hrdata=0; memory retains its prior values.
- Zero-wait WORD write/read: write 32'hDEADBEEF @0x10 (wait_states=0), then read @0x10 -> hreadyout stays 1, hrdata=32'hDEADBEEF in the read data cycle, hresp=0.
- Wait states: read @0x20 with wait_states=3 -> hreadyout low for exactly 3 cycles, then high with valid data; total data phase = 4 cycles.
- Byte/halfword writes with strobes:
  - Preload 0x0 in @0x40.
  - Write BYTE 8'hAA @0x41, then HALFWORD 16'h1234 @0x42 with hwstrb=4'b0100.
  - Read @0x40 -> 32'h0034AA00.
- Error responses:
  - Write @MAX_ADDR+4 -> cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1, memory unchanged.
  - Misaligned WORD @0x02 behaves the same.
  - hsize=DOUBLEWORD behaves the same.
- Pipelining: NONSEQ write @0x0 followed directly by SEQ read @0x0, wait_states=1 each -> read returns the just-written data; no dropped or duplicated accepts; IDLE cycles give zero-wait OKAY.
